// File: rtl/mac_fifo_array.sv
// mac_fifo_array: shared column FIFO feeding N pipelined
// multiply-accumulate rows under a start/len command FSM.
module mac_fifo_array #(
  parameter int N      = 8,
  parameter int DEPTH  = 16,
  parameter int DW     = 8,
  parameter int ACCW   = 24,
  parameter int SIGNED = 0,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [N*DW-1:0]   wr_a,
  input  logic [DW-1:0]     wr_b,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  input  logic              start,
  input  logic [CW-1:0]     len,
  input  logic              clr,
  output logic              busy,
  output logic              c_valid,
  output logic [N*ACCW-1:0] c_out,
  output logic [N-1:0]      overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   rem;
  logic            dcnt;
  logic            push;
  logic            pop;
  logic            zap;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [N*DW-1:0] mem_a [DEPTH];
  logic [DW-1:0]   mem_b [DEPTH];
  logic            v1;
  logic            v2;
  logic [N*DW-1:0] a_q;
  logic [DW-1:0]   b_q;
  logic [2*DW-1:0] prod  [N];
  logic [ACCW-1:0] acc   [N];
  logic [ACCW-1:0] pe    [N];
  logic [ACCW:0]   sum   [N];
  logic [ACCW-1:0] acc_n [N];
  logic [N-1:0]    ovf_n;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign push  = wr_en && !full;
  assign pop   = (state == RUN) && !empty;
  assign zap   = (state == IDLE) && (start || clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= wr_a;
      mem_b[wptr] <= wr_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      dcnt    <= 1'b0;
      busy    <= 1'b0;
      c_valid <= 1'b0;
    end else begin
      c_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            rem   <= len;
            dcnt  <= 1'b0;
            state <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!empty) begin
            rem <= rem - CW'(1);
            if (rem <= CW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= 1'b1;
          if (dcnt) state <= DONE;
        end
        DONE: begin
          c_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [2*DW-1:0] mul(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [2*DW-1:0] ae;
    logic [2*DW-1:0] be;
    if (SIGNED != 0) begin
      ae = (2*DW)'($signed(a));
      be = (2*DW)'($signed(b));
    end else begin
      ae = (2*DW)'(a);
      be = (2*DW)'(b);
    end
    // Low 2*DW bits of the extended product are exact either way.
    return ae * be;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (SIGNED != 0) pe[i] = ACCW'($signed(prod[i]));
      else pe[i] = ACCW'(prod[i]);
      sum[i]   = {1'b0, acc[i]} + {1'b0, pe[i]};
      acc_n[i] = sum[i][ACCW-1:0];
      if (SIGNED != 0)
        ovf_n[i] = (acc[i][ACCW-1] == pe[i][ACCW-1]) &&
                   (sum[i][ACCW-1] != acc[i][ACCW-1]);
      else
        ovf_n[i] = sum[i][ACCW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      overflow <= '0;
      for (int i = 0; i < N; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      v1 <= pop;
      v2 <= v1;
      if (pop) begin
        a_q <= mem_a[rptr];
        b_q <= mem_b[rptr];
      end
      for (int i = 0; i < N; i++) begin
        if (v1) prod[i] <= mul(a_q[i*DW +: DW], b_q);
        if (zap) begin
          acc[i]      <= '0;
          overflow[i] <= 1'b0;
        end else if (v2) begin
          acc[i] <= acc_n[i];
          if (ovf_n[i]) overflow[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    c_out = '0;
    for (int i = 0; i < N; i++) c_out[i*ACCW +: ACCW] = acc[i];
  end

endmodule

// File: tb/tb_mac_fifo_array.sv
// Bench for mac_fifo_array: unsigned (ACCW=16) and signed
// (ACCW=24) instances checked by a queue-based scoreboard.
module tb_mac_fifo_array;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  b;
  } ent_t;

  typedef struct packed {
    logic [95:0] c;
    logic [3:0]  ov;
    logic [7:0]  len;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        wr_en [2];
  logic [31:0] wr_a  [2];
  logic [7:0]  wr_b  [2];
  logic        start [2];
  logic [3:0]  len   [2];
  logic        clr   [2];
  logic        full  [2];
  logic        empty [2];
  logic [3:0]  count [2];
  logic        busy  [2];
  logic        c_valid [2];
  logic [3:0]  ovf   [2];
  logic [63:0] uc;
  logic [95:0] sc;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  ent_t mq [2][$];
  exp_t eq [2][$];
  int   pend [2] = '{-1, -1};
  int   inflight [2] = '{0, 0};
  int   ndone [2] = '{0, 0};
  int   vcyc [2] = '{0, 0};
  int   sedge [2] = '{0, 0};
  exp_t mon_e;

  mac_fifo_array #(.N(4), .DEPTH(8), .DW(8), .ACCW(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[0]), .wr_a(wr_a[0]), .wr_b(wr_b[0]),
    .full(full[0]), .empty(empty[0]), .count(count[0]),
    .start(start[0]), .len(len[0]), .clr(clr[0]),
    .busy(busy[0]), .c_valid(c_valid[0]),
    .c_out(uc), .overflow(ovf[0])
  );

  mac_fifo_array #(.N(4), .DEPTH(8), .DW(8), .ACCW(24), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[1]), .wr_a(wr_a[1]), .wr_b(wr_b[1]),
    .full(full[1]), .empty(empty[1]), .count(count[1]),
    .start(start[1]), .len(len[1]), .clr(clr[1]),
    .busy(busy[1]), .c_valid(c_valid[1]),
    .c_out(sc), .overflow(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  function automatic logic [95:0] act(int d);
    logic [95:0] x = '0;
    for (int r = 0; r < 4; r++)
      x[r*24 +: 24] = (d == 0) ? 24'(uc[r*16 +: 16]) : sc[r*24 +: 24];
    return x;
  endfunction

  function automatic int occ(int d);
    return mq[d].size() + inflight[d];
  endfunction

  // Dot products from plain integer arithmetic on the queued entries.
  function automatic exp_t calc(int d, int l);
    exp_t        e;
    ent_t        en;
    longint      acc;
    longint      p;
    logic [63:0] av;
    e = '0;
    e.len = 8'(l);
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int k = 0; k < l; k++) begin
        en = mq[d][k];
        if (d == 0) begin
          p = longint'(en.a[r*8 +: 8]) * longint'(en.b);
          acc += p;
          if (acc >= 65536) begin e.ov[r] = 1'b1; acc -= 65536; end
        end else begin
          p = longint'($signed(en.a[r*8 +: 8])) * longint'($signed(en.b));
          acc += p;
          if (acc > 8388607) begin e.ov[r] = 1'b1; acc -= 16777216; end
          else if (acc < -8388608) begin e.ov[r] = 1'b1; acc += 16777216; end
        end
      end
      av = acc;
      e.c[r*24 +: 24] = av[23:0];
    end
    for (int k = 0; k < l; k++) void'(mq[d].pop_front());
    return e;
  endfunction

  function automatic void resolve(int d);
    if (pend[d] >= 0 && mq[d].size() >= pend[d]) begin
      eq[d].push_back(calc(d, pend[d]));
      inflight[d] += pend[d];
      pend[d] = -1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(int d, logic [31:0] a, logic [7:0] b);
    ent_t en;
    en.a = a;
    en.b = b;
    wr_en[d] = 1'b1;
    wr_a[d]  = a;
    wr_b[d]  = b;
    if (occ(d) < 8) mq[d].push_back(en);
    resolve(d);
    tick();
    wr_en[d] = 1'b0;
  endtask

  task automatic start_cmd(int d, int l);
    start[d] = 1'b1;
    len[d]   = 4'(l);
    pend[d]  = l;
    sedge[d] = cyc + 1;
    resolve(d);
    tick();
    start[d] = 1'b0;
  endtask

  task automatic wait_done(int d, int tgt, int maxc);
    int n = 0;
    while (ndone[d] < tgt && n < maxc) begin
      tick();
      n++;
    end
    chk($sformatf("d%0d_done_in_time", d), 128'(ndone[d] >= tgt), 1);
  endtask

  task automatic rand_cmd(int d);
    int k, l, avail, more, tgt;
    k = $urandom_range(0, 8 - occ(d));
    repeat (k) do_push(d, $urandom, 8'($urandom));
    avail = mq[d].size();
    l = $urandom_range(0, 8);
    tgt = ndone[d] + 1;
    start_cmd(d, l);
    more = (l > avail ? l - avail : 0) + $urandom_range(0, 2);
    for (int j = 0; j < more; j++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (occ(d) < 8) do_push(d, $urandom, 8'($urandom));
    end
    wait_done(d, tgt, 100);
    chk($sformatf("d%0d_rand_count", d), count[d], 128'(mq[d].size()));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (c_valid[d]) begin
          ndone[d]++;
          vcyc[d] = cyc;
          chk($sformatf("d%0d_busy_at_valid", d), busy[d], 0);
          if (eq[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL d%0d_unexpected_c_valid: got c_valid=1 expected none", d);
          end else begin
            mon_e = eq[d].pop_front();
            inflight[d] -= int'(mon_e.len);
            chk($sformatf("d%0d_c_out", d), act(d), mon_e.c);
            chk($sformatf("d%0d_overflow", d), ovf[d], mon_e.ov);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, e2;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 0; wr_a[d] = 0; wr_b[d] = 0;
      start[d] = 0; len[d] = 0; clr[d] = 0;
    end
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_count", count[d], 0);
      chk("rst_empty", empty[d], 1);
      chk("rst_full", full[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_c_valid", c_valid[d], 0);
      chk("rst_c_out", act(d), 0);
      chk("rst_overflow", ovf[d], 0);
    end
    rst_n = 1'b1;
    tick();

    do_push(0, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd10);
    do_push(0, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd20);
    do_push(0, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd30);
    tgt = ndone[0] + 1;
    start_cmd(0, 3);
    wait_done(0, tgt, 20);
    chk("t1_latency", 128'(vcyc[0] - sedge[0]), 6);
    chk("t1_row0", uc[15:0], 60);
    chk("t1_row3", uc[63:48], 240);
    chk("t1_count", count[0], 0);

    repeat (8) do_push(0, 32'hFFFF_FFFF, 8'hFF);
    tgt = ndone[0] + 1;
    start_cmd(0, 8);
    wait_done(0, tgt, 30);
    chk("t2_row0_wrap", uc[15:0], 61448);
    chk("t2_ovf0", ovf[0][0], 1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("t2_clr_c_out", act(0), 0);
    chk("t2_clr_ovf", ovf[0], 0);

    tgt = ndone[0] + 1;
    start_cmd(0, 2);
    repeat (5) begin
      chk("t3_stall_busy", busy[0], 1);
      chk("t3_stall_count", count[0], 0);
      tick();
    end
    do_push(0, {4{8'd1}}, 8'd7);
    e2 = cyc + 1;
    do_push(0, {4{8'd1}}, 8'd7);
    wait_done(0, tgt, 20);
    chk("t3_latency", 128'(vcyc[0] - e2), 4);
    chk("t3_row2", uc[47:32], 14);

    for (int i = 0; i < 9; i++) begin
      do_push(0, $urandom, 8'($urandom));
      if (i == 7) chk("t4_full_at_8", full[0], 1);
    end
    chk("t4_count_8", count[0], 8);
    tgt = ndone[0] + 1;
    start_cmd(0, 0);
    wait_done(0, tgt, 10);
    chk("t4_len0_latency", 128'(vcyc[0] - sedge[0]), 1);
    chk("t4_len0_count", count[0], 8);
    tgt = ndone[0] + 1;
    start_cmd(0, 8);
    tick();
    tick();
    start[0] = 1'b1;
    len[0]   = 4'd3;
    tick();
    start[0] = 1'b0;
    wait_done(0, tgt, 30);
    repeat (10) tick();
    chk("t4_busy_start_ignored", ndone[0], tgt);
    chk("t4_drained_count", count[0], 0);

    repeat (8) rand_cmd(0);

    do_push(1, {4{8'hFD}}, 8'd5);
    tgt = ndone[1] + 1;
    start_cmd(1, 1);
    wait_done(1, tgt, 20);
    chk("t6_signed_row0", sc[23:0], 24'hFFFFF1);
    repeat (6) rand_cmd(1);

    repeat (3) do_push(1, $urandom, 8'($urandom));
    tgt = ndone[1];
    start_cmd(1, 5);
    repeat (4) tick();
    chk("t7_running_busy", busy[1], 1);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      eq[d].delete();
      pend[d] = -1;
      inflight[d] = 0;
    end
    #1;
    chk("t7_rst_count", count[1], 0);
    chk("t7_rst_empty", empty[1], 1);
    chk("t7_rst_busy", busy[1], 0);
    chk("t7_rst_c_out", act(1), 0);
    chk("t7_rst_ovf", ovf[1], 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t7_no_c_valid", ndone[1], tgt);
    chk("t7_empty_after", empty[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
